// File: rtl/bcd_countdown_timer_if.sv
// Keypad/run-control bundle for bcd_countdown_timer.
// The master side (keypad encoder, front panel) drives the key and control strobes.
// The slave side (the timer) returns the digit, run and status outputs.
interface bcd_countdown_timer_if #(
    parameter int MIN_DIGITS = 1
);
    logic                    key_valid;
    logic [3:0]              key_digit;
    logic                    entry_clr;
    logic                    start;
    logic                    stop;
    logic                    door_closed;
    logic                    run;
    logic [3:0]              sec_ones;
    logic [3:0]              sec_tens;
    logic [4*MIN_DIGITS-1:0] mins;
    logic                    zero;
    logic                    done;
    logic                    tick;

    modport master (
        output key_valid, key_digit, entry_clr, start, stop, door_closed,
        input  run, sec_ones, sec_tens, mins, zero, done, tick
    );

    modport slave (
        input  key_valid, key_digit, entry_clr, start, stop, door_closed,
        output run, sec_ones, sec_tens, mins, zero, done, tick
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown timer with keypad entry, tick prescaler and run-control FSM.
// Digits are shifted in from the right, counted down once per prescaled tick,
// and the countdown can be paused by stop or an open door and resumed by start.
// Optional macro QUICK_START_EN: start with a zero time loads 0:30 and runs.
module bcd_countdown_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int CLK_HZ     = 1000,
    parameter int TICK_HZ    = 1
) (
    input logic                    clk,
    input logic                    clr,
    bcd_countdown_timer_if.slave   bus
);
    localparam int             DIV      = CLK_HZ / TICK_HZ;
    localparam int             PW       = $clog2(DIV);
    localparam logic [PW-1:0]  DIV_LAST = PW'(DIV - 1);
    localparam int             MW       = 4 * MIN_DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state_q;
    logic [3:0]      ones_q;
    logic [3:0]      tens_q;
    logic [MW-1:0]   mins_q;
    logic [PW-1:0]   presc_q;
    logic            run_q;
    logic            done_q;
    logic            tick_q;

    logic [3:0]      dec_ones;
    logic [3:0]      dec_tens;
    logic [MW-1:0]   dec_mins;
    logic            dec_zero;
    logic            borrow;
    logic            zero_w;
    logic            key_ok;
    logic            start_ok;
    logic [MW-1:0]   shift_mins;

    assign zero_w     = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == '0);
    assign key_ok     = bus.key_valid && (bus.key_digit <= 4'd9);
    assign start_ok   = bus.start && !bus.stop && bus.door_closed;
    assign shift_mins = MW'({mins_q, tens_q});

    // One-second BCD decrement: seconds units wrap to 9, seconds tens wrap to 5,
    // every minute digit wraps to 9, with the borrow rippling upward.
    always_comb begin
        dec_ones = ones_q;
        dec_tens = tens_q;
        dec_mins = mins_q;
        borrow   = 1'b0;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            borrow   = 1'b1;
        end
        if (borrow) begin
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
                borrow   = 1'b0;
            end else begin
                dec_tens = 4'd5;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (mins_q[4*i +: 4] != 4'd0) begin
                    dec_mins[4*i +: 4] = mins_q[4*i +: 4] - 4'd1;
                    borrow             = 1'b0;
                end else begin
                    dec_mins[4*i +: 4] = 4'd9;
                end
            end
        end
        dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == '0);
    end

    // Run-control FSM with digit entry, prescaler and registered run/done/tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            mins_q  <= '0;
            presc_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok && !zero_w) begin
                        state_q <= RUN;
                        presc_q <= '0;
                        run_q   <= 1'b1;
                    end
`ifdef QUICK_START_EN
                    else if (start_ok) begin
                        ones_q  <= 4'd0;
                        tens_q  <= 4'd3;
                        mins_q  <= '0;
                        state_q <= RUN;
                        presc_q <= '0;
                        run_q   <= 1'b1;
                    end
`endif
                    else if (bus.entry_clr) begin
                        ones_q <= 4'd0;
                        tens_q <= 4'd0;
                        mins_q <= '0;
                    end else if (key_ok) begin
                        ones_q <= bus.key_digit;
                        tens_q <= ones_q;
                        mins_q <= shift_mins;
                    end
                end
                RUN: begin
                    if (bus.stop || !bus.door_closed) begin
                        state_q <= PAUSE;
                        run_q   <= 1'b0;
                    end else if (presc_q == DIV_LAST) begin
                        presc_q <= '0;
                        tick_q  <= 1'b1;
                        ones_q  <= dec_ones;
                        tens_q  <= dec_tens;
                        mins_q  <= dec_mins;
                        if (dec_zero) begin
                            state_q <= DONE;
                            run_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        ones_q  <= 4'd0;
                        tens_q  <= 4'd0;
                        mins_q  <= '0;
                    end else if (bus.start && bus.door_closed) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (key_ok) begin
                        ones_q <= bus.key_digit;
                        tens_q <= ones_q;
                        mins_q <= shift_mins;
                    end
                    if (bus.start || bus.stop || bus.key_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.run      = run_q;
    assign bus.done     = done_q;
    assign bus.tick     = tick_q;
    assign bus.sec_ones = ones_q;
    assign bus.sec_tens = tens_q;
    assign bus.mins     = mins_q;
    assign bus.zero     = zero_w;
endmodule
